// File: rtl/harvard_pkg.sv
// harvard_pkg: shared definitions for the 16-bit Harvard core decode path.
//   - opcode constants OP_LDI..OP_SHR (opcode field is instr[31:26])
//   - op_class_e / alu_op_e encodings presented to execute
//   - dec_bundle_t: every payload field the decode stage presents
//   - decode_instr(): pure combinational decoder, shared by RTL and bench
package harvard_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_MAX_W = 16;
  localparam int ADDR_MAX_W = 16;

  localparam logic [5:0] OP_LDI  = 6'd0;
  localparam logic [5:0] OP_MOV  = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_ADD  = 6'd4;
  localparam logic [5:0] OP_SUB  = 6'd5;
  localparam logic [5:0] OP_NEG  = 6'd6;
  localparam logic [5:0] OP_MUL  = 6'd7;
  localparam logic [5:0] OP_AND  = 6'd8;
  localparam logic [5:0] OP_OR   = 6'd9;
  localparam logic [5:0] OP_XOR  = 6'd10;
  localparam logic [5:0] OP_NAND = 6'd11;
  localparam logic [5:0] OP_NOR  = 6'd12;
  localparam logic [5:0] OP_XNOR = 6'd13;
  localparam logic [5:0] OP_NOT  = 6'd14;
  localparam logic [5:0] OP_SHL  = 6'd15;
  localparam logic [5:0] OP_SHR  = 6'd16;

  typedef enum logic [2:0] {
    CLS_LDI = 3'd0,
    CLS_MOV = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_ALU = 3'd4,
    CLS_ILL = 3'd7
  } op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_NEG  = 4'd2,
    ALU_MUL  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NAND = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_XNOR = 4'd9,
    ALU_NOT  = 4'd10,
    ALU_SHL  = 4'd11,
    ALU_SHR  = 4'd12
  } alu_op_e;

  // imm/addr are carried at their maximum width; the stage slices them to
  // DATA_W / MA_W at its ports (upper bits are always zero).
  typedef struct packed {
    op_class_e             cls;
    alu_op_e               alu_op;
    logic [4:0]            rd2;
    logic [4:0]            rd1;
    logic [4:0]            rs2;
    logic [4:0]            rs1;
    logic                  rd2_en;
    logic                  rd1_en;
    logic                  rs2_en;
    logic                  rs1_en;
    logic [IMM_MAX_W-1:0]  imm;
    logic [ADDR_MAX_W-1:0] addr;
    logic                  mem_re;
    logic                  mem_we;
  } dec_bundle_t;

  // Crack one instruction word. data_w / ma_w select the immediate and
  // address widths; fields not used by an opcode stay zero.
  function automatic dec_bundle_t decode_instr(input logic [INSTR_W-1:0] instr,
                                               input int unsigned data_w,
                                               input int unsigned ma_w);
    dec_bundle_t d;
    logic [5:0]  opc;
    logic [4:0]  imm_sh;
    logic [4:0]  addr_sh;
    d       = '0;
    opc     = instr[31:26];
    imm_sh  = 5'(IMM_MAX_W - data_w);
    addr_sh = 5'(ADDR_MAX_W - ma_w);
    if (opc == OP_LDI) begin
      d.cls    = CLS_LDI;
      d.rd2    = instr[25:21];
      d.rd2_en = 1'b1;
      d.imm    = instr[15:0] & (16'hFFFF >> imm_sh);
    end else if (opc == OP_MOV) begin
      d.cls    = CLS_MOV;
      d.rd2    = instr[25:21];
      d.rd2_en = 1'b1;
      d.rs1    = instr[4:0];
      d.rs1_en = 1'b1;
    end else if (opc == OP_LD) begin
      d.cls    = CLS_LD;
      d.rd2    = instr[25:21];
      d.rd2_en = 1'b1;
      d.addr   = instr[15:0] & (16'hFFFF >> addr_sh);
      d.mem_re = 1'b1;
    end else if (opc == OP_ST) begin
      // Store address sits left-justified at [25:26-MA_W].
      d.cls    = CLS_ST;
      d.addr   = instr[25:10] >> addr_sh;
      d.rs1    = instr[4:0];
      d.rs1_en = 1'b1;
      d.mem_we = 1'b1;
    end else if ((opc >= OP_ADD) && (opc <= OP_SHR)) begin
      d.cls    = CLS_ALU;
      d.alu_op = alu_op_e'(4'(opc - OP_ADD));
      d.rd1    = instr[20:16];
      d.rd1_en = 1'b1;
      d.rs1    = instr[4:0];
      d.rs1_en = 1'b1;
      // Unary ops have no second source.
      if ((opc == OP_NEG) || (opc == OP_NOT)) begin
        d.rs2    = 5'd0;
        d.rs2_en = 1'b0;
      end else begin
        d.rs2    = instr[9:5];
        d.rs2_en = 1'b1;
      end
      // MUL writes the high half to rd2, low half to rd1.
      if (opc == OP_MUL) begin
        d.rd2    = instr[25:21];
        d.rd2_en = 1'b1;
      end else begin
        d.rd2    = 5'd0;
        d.rd2_en = 1'b0;
      end
    end else begin
      d.cls = CLS_ILL;
    end
    return d;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: generic two-entry valid/ready skid buffer with flush.
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous invalidate of both entries; wins over transfers
//   in_valid/in_ready   upstream handshake (in_ready is registered = !skid_full)
//   in_data [W]         payload captured on an input transfer
//   out_valid/out_ready downstream handshake, out_data is the output register
module dec_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         or_valid_q, or_valid_d;
  logic [W-1:0] or_data_q, or_data_d;
  logic         sr_valid_q, sr_valid_d;
  logic [W-1:0] sr_data_q, sr_data_d;
  logic         rdy_q, rdy_d;
  logic         in_fire_s;
  logic         out_fire_s;

  assign in_fire_s  = in_valid & rdy_q;
  assign out_fire_s = or_valid_q & out_ready;

  // Next-state for output register, skid register and registered ready.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sr_valid_d = sr_valid_q;
    sr_data_d  = sr_data_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (out_fire_s && sr_valid_q) begin
      // in_ready is low whenever the skid is full, so no input competes here.
      or_valid_d = 1'b1;
      or_data_d  = sr_data_q;
      sr_valid_d = 1'b0;
    end else if (in_fire_s) begin
      if (!or_valid_q || out_fire_s) begin
        or_valid_d = 1'b1;
        or_data_d  = in_data;
      end else begin
        sr_valid_d = 1'b1;
        sr_data_d  = in_data;
      end
    end else if (out_fire_s) begin
      or_valid_d = 1'b0;
    end else begin
      or_valid_d = or_valid_q;
      sr_valid_d = sr_valid_q;
    end
    rdy_d = ~sr_valid_d;
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      sr_valid_q <= 1'b0;
      sr_data_q  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      sr_valid_q <= sr_valid_d;
      sr_data_q  <= sr_data_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode for the 16-bit Harvard core.
//   clk, rst_n            clock, async active-low reset
//   flush                 drops buffered decodes and any same-cycle input
//   in_valid/in_ready     fetch handshake, in_instr[31:0] (opcode = [31:26])
//   out_valid/out_ready   execute handshake
//   out_class, out_alu_op decoded op class and ALU op
//   out_rd2/rd1/rs2/rs1   register indices, *_en marks fields in use
//   out_imm, out_addr     immediate (DATA_W) and data address (MA_W)
//   out_mem_re/we         memory read / write strobes
//   illegal_cnt           saturating count of accepted illegal opcodes
module decode_stage
  import harvard_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MA_W   = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_class,
  output logic [3:0]        out_alu_op,
  output logic [4:0]        out_rd2,
  output logic [4:0]        out_rd1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rs1,
  output logic              out_rd2_en,
  output logic              out_rd1_en,
  output logic              out_rs2_en,
  output logic              out_rs1_en,
  output logic [DATA_W-1:0] out_imm,
  output logic [MA_W-1:0]   out_addr,
  output logic              out_mem_re,
  output logic              out_mem_we,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int BUNDLE_W = $bits(dec_bundle_t);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  dec_bundle_t         dec_s;
  dec_bundle_t         out_b_s;
  logic [BUNDLE_W-1:0] out_vec_s;
  logic                in_fire_s;
  logic [CNT_W-1:0]    illegal_cnt_q, illegal_cnt_d;

  // Decode the incoming word combinationally; the skid buffer registers it.
  always_comb begin
    dec_s = decode_instr(in_instr, DATA_W, MA_W);
  end

  dec_skid_buf #(
    .W(BUNDLE_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_vec_s)
  );

  assign out_b_s   = out_vec_s;
  assign in_fire_s = in_valid & in_ready;

  // Illegal-opcode counter next state; a flushed input is not counted.
  always_comb begin
    if (in_fire_s && !flush && (dec_s.cls == CLS_ILL) && (illegal_cnt_q != CNT_MAX)) begin
      illegal_cnt_d = illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      illegal_cnt_d = illegal_cnt_q;
    end
  end

  // Illegal-opcode counter register; flush intentionally leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
  assign out_class   = out_b_s.cls;
  assign out_alu_op  = out_b_s.alu_op;
  assign out_rd2     = out_b_s.rd2;
  assign out_rd1     = out_b_s.rd1;
  assign out_rs2     = out_b_s.rs2;
  assign out_rs1     = out_b_s.rs1;
  assign out_rd2_en  = out_b_s.rd2_en;
  assign out_rd1_en  = out_b_s.rd1_en;
  assign out_rs2_en  = out_b_s.rs2_en;
  assign out_rs1_en  = out_b_s.rs1_en;
  assign out_imm     = out_b_s.imm[DATA_W-1:0];
  assign out_addr    = out_b_s.addr[MA_W-1:0];
  assign out_mem_re  = out_b_s.mem_re;
  assign out_mem_we  = out_b_s.mem_we;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the 16-bit Harvard core. It accepts 32-bit instruction words from fetch over a valid/ready handshake and cracks each word into an op class, an ALU op, register indices with use-enables, an immediate and a data-memory address. A two-entry skid buffer lets it absorb back-pressure from execute without bubbles. It also supports a pipeline flush and keeps a saturating count of illegal opcodes.

## Interface
Parameters:
- DATA_W, 16, datapath width; legal range 8..16.
- MA_W, 8, data-memory address width; legal range 4..16.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards buffered and in-flight decodes.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word; opcode is [31:26].
- out_valid  out  1  a decoded instruction is presented.
- out_ready  in  1  execute accepts it.
- out_class  out  3  op class: LDI=0, MOV=1, LD=2, ST=3, ALU=4, ILL=7.
- out_alu_op  out  4  ADD=0 SUB NEG MUL AND OR XOR NAND NOR XNOR NOT SHL SHR=12; 0 for non-ALU.
- out_rd2, out_rd1, out_rs2, out_rs1  out  5 each  register indices.
- out_rd2_en, out_rd1_en, out_rs2_en, out_rs1_en  out  1 each  field is used.
- out_imm  out  DATA_W  immediate.
- out_addr  out  MA_W  data-memory address.
- out_mem_re, out_mem_we  out  1  memory read / write.
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes accepted.

## Operation
- An input transfer happens when in_valid and in_ready are both 1. An output transfer happens when out_valid and out_ready are both 1.
- Decode table. Unlisted fields are driven to 0 and their enables to 0.
  - Opcode 0, LDI: rd2=[25:21], imm=[DATA_W-1:0].
  - Opcode 1, MOV: rd2=[25:21], rs1=[4:0].
  - Opcode 2, LD: rd2=[25:21], addr=[MA_W-1:0], mem_re=1.
  - Opcode 3, ST: addr=[25:26-MA_W], rs1=[4:0], mem_we=1.
  - Opcodes 4..16, ALU: alu_op=opcode-4, rd1=[20:16], rs2=[9:5], rs1=[4:0].
    - NEG and NOT: rs2_en=0.
    - MUL: also rd2=[25:21] with rd2_en=1 (rd2 takes the high half, rd1 the low half).
  - Opcodes 17..63: class ILL, all other outputs 0. The word still transfers downstream.
- illegal_cnt increments by 1 on each accepted ILL word and saturates at 2^CNT_W-1. flush does not clear it.
- Skid buffer, two entries: an output register (OR) and a skid register (SR).
  - The input is decoded combinationally and captured as a whole bundle.
  - If OR is empty, or OR is draining this cycle and SR is empty, the bundle goes to OR. Otherwise it goes to SR.
  - When OR drains and SR is full, SR moves to OR.
  - in_ready is registered and equals !SR_full.
- flush has priority over every transfer. In the flush cycle, any input is dropped and does not count toward illegal_cnt. Both entries are invalidated, and from the next cycle out_valid=0 and in_ready=1.

## Timing
- Reset: out_valid=0, in_ready=1, every payload output=0, illegal_cnt=0. An asserted rst_n mid-transfer discards all state immediately.
- Latency is 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 word per cycle while out_ready=1.
- Back-pressure: after out_ready drops, one more word is absorbed into SR, then in_ready=0 from the next cycle.
- Recovery: on the first cycle out_ready=1, SR moves into OR and in_ready returns to 1 the following cycle. No word is lost or duplicated.
- Payload holds stable while out_valid=1 and out_ready=0.
- Accept and drain in the same cycle with SR empty keeps occupancy unchanged and out_valid=1.

## Structure
- harvard_pkg holds:
  - opcode localparams, OP_LDI..OP_SHR;
  - the op_class_e and alu_op_e enums;
  - a dec_bundle_t struct holding every out_* payload field;
  - a pure function decode_instr(instr) returning dec_bundle_t, reused by the bench model.
- Sub-module dec_skid_buf is a generic 2-entry valid/ready skid buffer with flush, parametrised on payload width.

## Test plan
- Streaming with out_ready=1: send 0x1041_0022 (opcode 4, ADD). It appears next cycle as class 4, alu_op 0, rd1=1, rs2=1, rs1=2; then one word per cycle.
- Send 0x0000_ABCD (LDI) with DATA_W=16: rd2=0, imm=0xABCD, rd2_en=1. Send 0x0C40_0003 (ST): addr=0x10, rs1=3, mem_we=1.
- Send opcodes 17 and 63, and 300 illegal words with CNT_W=8: class 7, all outputs 0, illegal_cnt stops at 255.
- Hold out_ready=0 while streaming 5 words: exactly 2 are accepted and in_ready falls. Release: all 5 exit in order with no duplicates.
- With both entries full, pulse flush alongside in_valid: next cycle out_valid=0 and in_ready=1, the dropped word never appears, illegal_cnt is unchanged.
- Assert rst_n low mid-stream: outputs reach reset values immediately. After release, the first word has 1-cycle latency.
